// File: rtl/multi_note_timer.sv
// multi_note_timer
// ----------------
// A bank of N_CH independent note-length timers. Each channel counts one
// note down, one step per beat tick. When a note finishes, the channel either
// stops at zero or reloads the length it last latched (loop mode). Channels
// share only the clock, reset, pause and beat inputs.
//
// Ports
//   clk_i           : single clock, all state updates on the rising edge
//   reset_i         : synchronous, active-high reset
//   load_i          : per-channel load strobe (bit i loads channel i)
//   load_len_i      : note lengths in beats, channel i at [i*LEN_W +: LEN_W]
//   repeat_i        : per-channel loop mode, sampled on the ending beat
//   pause_i         : global freeze of every channel counter
//   beat_i          : one-cycle beat tick shared by all channels
//   remaining_o     : current counter per channel, same packing as load_len_i
//   note_did_end_o  : channel counter is zero and its load strobe is low
//   end_pulse_o     : registered one-cycle pulse per completed note
//   all_done_o      : AND of all note_did_end_o bits
//
// The loop-mode input is called repeat_i because "repeat" is a reserved
// word in SystemVerilog.
module multi_note_timer #(
    parameter int N_CH  = 4,
    parameter int LEN_W = 6
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [N_CH-1:0]         load_i,
    input  logic [N_CH*LEN_W-1:0]   load_len_i,
    input  logic [N_CH-1:0]         repeat_i,
    input  logic                    pause_i,
    input  logic                    beat_i,
    output logic [N_CH*LEN_W-1:0]   remaining_o,
    output logic [N_CH-1:0]         note_did_end_o,
    output logic [N_CH-1:0]         end_pulse_o,
    output logic                    all_done_o
);

    // Packed so that channel i lands at bits [i*LEN_W +: LEN_W].
    logic [N_CH-1:0][LEN_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][LEN_W-1:0] len_q, len_d;
    logic [N_CH-1:0]            end_pulse_q, end_pulse_d;

    // Next-state per channel. A load beats pause, pause beats the beat tick.
    // The ending beat (counter at one) either reloads the latched length or
    // parks at zero, and arms the end pulse for the following cycle. A
    // counter already at zero simply stays there.
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        end_pulse_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (load_i[i]) begin
                cnt_d[i] = load_len_i[i*LEN_W +: LEN_W];
                len_d[i] = load_len_i[i*LEN_W +: LEN_W];
            end else if (!pause_i && beat_i) begin
                if (cnt_q[i] > LEN_W'(1)) begin
                    cnt_d[i] = cnt_q[i] - LEN_W'(1);
                end else if (cnt_q[i] == LEN_W'(1)) begin
                    cnt_d[i]       = repeat_i[i] ? len_q[i] : '0;
                    end_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers; reset abandons any note in flight without a pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            len_q       <= '0;
            end_pulse_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            end_pulse_q <= end_pulse_d;
        end
    end

    // The done level is masked by the load strobe so a channel never looks
    // finished in the same cycle it is being given a new note.
    always_comb begin
        note_did_end_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            note_did_end_o[i] = (cnt_q[i] == '0) && !load_i[i];
        end
    end

    assign remaining_o = cnt_q;
    assign end_pulse_o = end_pulse_q;
    assign all_done_o  = &note_did_end_o;

endmodule

// File: tb/tb_multi_note_timer.sv
// tb_multi_note_timer
// -------------------
// Scoreboard bench for multi_note_timer. The stimulus process drives one
// set of inputs per cycle, asks the reference model what the outputs must
// look like during that cycle, queues that expectation and then advances the
// model. A separate monitor pops one expectation per cycle and compares.
module tb_multi_note_timer;

    localparam int N_CH  = 4;
    localparam int LEN_W = 6;
    localparam int W     = N_CH * LEN_W;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] load;
    logic [W-1:0]    loadLen;
    logic [N_CH-1:0] rpt;
    logic            pause;
    logic            beat;
    logic [W-1:0]    remaining;
    logic [N_CH-1:0] noteDidEnd;
    logic [N_CH-1:0] endPulse;
    logic            allDone;

    multi_note_timer #(.N_CH(N_CH), .LEN_W(LEN_W)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .load_i         (load),
        .load_len_i     (loadLen),
        .repeat_i       (rpt),
        .pause_i        (pause),
        .beat_i         (beat),
        .remaining_o    (remaining),
        .note_did_end_o (noteDidEnd),
        .end_pulse_o    (endPulse),
        .all_done_o     (allDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    rem;
        logic [N_CH-1:0] ep;
        logic [N_CH-1:0] nde;
        logic            ad;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers per channel describing the note rules.
    int              mCnt[N_CH];
    int              mLen[N_CH];
    logic [N_CH-1:0] mPulse;

    function automatic logic [W-1:0] packLen(input int ch, input int v);
        logic [W-1:0] r;
        r = '0;
        r[ch*LEN_W +: LEN_W] = LEN_W'(v);
        return r;
    endfunction

    // Outputs visible during a cycle, given the model state and this cycle's load.
    function automatic exp_t predict(input logic [N_CH-1:0] ld);
        exp_t e;
        e.rem = '0;
        e.nde = '0;
        for (int i = 0; i < N_CH; i++) begin
            e.rem[i*LEN_W +: LEN_W] = LEN_W'(mCnt[i]);
            e.nde[i] = (mCnt[i] == 0) && !ld[i];
        end
        e.ep = mPulse;
        e.ad = (e.nde == {N_CH{1'b1}});
        return e;
    endfunction

    // One clock of the note rules.
    task automatic modelStep(input logic [N_CH-1:0] ld, input logic [W-1:0] lens,
                             input logic [N_CH-1:0] rp, input logic pz,
                             input logic bt, input logic rs);
        logic [N_CH-1:0] np;
        np = '0;
        if (rs) begin
            for (int i = 0; i < N_CH; i++) begin
                mCnt[i] = 0;
                mLen[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ld[i]) begin
                    mCnt[i] = int'(lens[i*LEN_W +: LEN_W]);
                    mLen[i] = mCnt[i];
                end else if (!pz && bt) begin
                    if (mCnt[i] > 1) begin
                        mCnt[i] = mCnt[i] - 1;
                    end else if (mCnt[i] == 1) begin
                        mCnt[i] = rp[i] ? mLen[i] : 0;
                        np[i] = 1'b1;
                    end
                end
            end
        end
        mPulse = np;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic applyStimulus(input logic [N_CH-1:0] ld, input logic [W-1:0] lens,
                                 input logic [N_CH-1:0] rp, input logic pz,
                                 input logic bt, input logic rs, input bit expect_valid);
        @(negedge clk);
        load    = ld;
        loadLen = lens;
        rpt     = rp;
        pause   = pz;
        beat    = bt;
        reset   = rs;
        if (expect_valid) sbq.push_back(predict(ld));
        modelStep(ld, lens, rp, pz, bt, rs);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: once per cycle, after the stimulus settled, compare the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("remaining",    remaining,           e.rem);
                checkOutput("end_pulse",    W'(endPulse),        W'(e.ep));
                checkOutput("note_did_end", W'(noteDidEnd),      W'(e.nde));
                checkOutput("all_done",     W'(allDone),         W'(e.ad));
            end
        end
    end

    initial begin
        load = '0; loadLen = '0; rpt = '0; pause = 1'b0; beat = 1'b0; reset = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            mCnt[i] = 0;
            mLen[i] = 0;
        end
        mPulse = '0;

        // Initial reset: DUT state unknown until this edge, so nothing is expected.
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // ch0, length 3, three beats then rest.
        applyStimulus(4'b0001, packLen(0, 3), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // ch1, length 2, looping, five beats.
        applyStimulus(4'b0010, packLen(1, 2), 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus('0, '0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // ch2, length 4, paused across three beats, then four beats.
        applyStimulus(4'b0100, packLen(2, 4), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus('0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // ch3 at one, reloaded with 5 on the same cycle as a beat.
        applyStimulus(4'b1000, packLen(3, 1), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1000, packLen(3, 5), '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Idle channels at zero take ten beats; then a zero-length load.
        for (int k = 0; k < 10; k++) applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001, packLen(0, 0), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-note while a beat is high.
        applyStimulus(4'b0001, packLen(0, 2), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Length one looping on back-to-back beats.
        applyStimulus(4'b0001, packLen(0, 1), 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus('0, '0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            logic [N_CH-1:0] ld;
            logic [W-1:0]    lens;
            ld   = '0;
            lens = '0;
            for (int i = 0; i < N_CH; i++) begin
                ld[i] = ($urandom_range(0, 9) == 0);
                lens[i*LEN_W +: LEN_W] = ($urandom_range(0, 7) == 0)
                                         ? LEN_W'($urandom_range(0, (1 << LEN_W) - 1))
                                         : LEN_W'($urandom_range(0, 5));
            end
            applyStimulus(ld, lens, N_CH'($urandom), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 60) == 0), 1'b1);
        end
        idle(1);

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #4;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_note_timer.md
MULTI_NOTE_TIMER -- requirements
Module: multi_note_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent note channels (1..16).
REQ-002 SHALL have parameter LEN_W, default 6, width of note length / beat counter per channel (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  N_CH  per-channel load strobe; bit i loads channel i.
REQ-006 SHALL have port load_len  input  N_CH*LEN_W  note lengths in beats; channel i at bits [i*LEN_W +: LEN_W].
REQ-007 SHALL have port repeat  input  N_CH  per-channel loop mode; 1 = auto-reload latched length at note end.
REQ-008 SHALL have port pause  input  1  global freeze of all channel counters.
REQ-009 SHALL have port beat  input  1  one-cycle beat tick shared by all channels.
REQ-010 SHALL have port remaining  output  N_CH*LEN_W  current counter value per channel, same packing as load_len.
REQ-011 SHALL have port note_did_end  output  N_CH  level: channel i counter is zero and load[i] is low.
REQ-012 SHALL have port end_pulse  output  N_CH  registered one-cycle pulse per completed note.
REQ-013 SHALL have port all_done  output  1  AND of all note_did_end bits.

Function
REQ-014 Each channel SHALL hold a counter cnt_i (LEN_W bits) and a latched length len_i (LEN_W bits).
REQ-015 Per-channel next-state priority SHALL be: reset > load[i] > pause > beat > hold.
REQ-016 On load[i]: cnt_i <= load_len_i and len_i <= load_len_i in the same cycle; other channels unaffected.
REQ-017 On pause (no load[i]): cnt_i holds; beat ignored; end_pulse_i SHALL not fire.
REQ-018 On beat, not paused, cnt_i > 1: cnt_i <= cnt_i - 1.
REQ-019 On beat, not paused, cnt_i == 1: cnt_i <= (repeat[i] ? len_i : 0); end_pulse_i high the following cycle only.
REQ-020 On beat, not paused, cnt_i == 0: cnt_i stays 0 (no wrap to all-ones); no end_pulse_i.
REQ-021 Load with load_len_i == 0: cnt_i = 0 next cycle; note_did_end_i high from then; no end_pulse_i.
REQ-022 repeat[i] sampled at the ending beat; repeat with len_i == 0 unreachable (counter never at 1), channel stays 0.
REQ-023 load[i] coincident with beat: load wins, no decrement; end_pulse_i SHALL not fire even if cnt_i was 1.
REQ-024 note_did_end_i SHALL be combinational: (cnt_i == 0) & ~load[i]; low in any cycle load[i] is high.
REQ-025 remaining SHALL directly reflect cnt registers; zero-latency, no combinational path from load_len.
REQ-026 end_pulse SHALL be a registered output, never high two consecutive cycles for one channel unless len_i == 1, repeat[i] = 1 and beat is high on consecutive cycles.
REQ-027 Channels SHALL be fully independent except for shared pause, beat, reset.

Reset
REQ-028 On reset: all cnt_i = 0, all len_i = 0, end_pulse = 0; overrides load, pause, beat in that cycle.
REQ-029 After reset: note_did_end = all ones (if load low), all_done = 1, remaining = 0.
REQ-030 Reset mid-note SHALL abandon the note without an end_pulse.

Verification
REQ-031 Defaults; load ch0 len 3, 3 beats no pause -> remaining0 3,2,1,0; end_pulse[0] high exactly one cycle after 3rd beat; note_did_end[0] high from then.
REQ-032 Load ch1 len 2, repeat[1]=1, 5 beats -> remaining1 2,1,2,1,2; end_pulse[1] after beats 2 and 4; note_did_end[1] never high.
REQ-033 Load ch2 len 4, pause high across 3 beats, then 4 beats -> counter holds 4 while paused, ends after 4 unpaused beats.
REQ-034 ch3 cnt=1, load[3]=1 with load_len 5 and beat same cycle -> remaining3 = 5, no end_pulse[3], note_did_end[3] low that cycle.
REQ-035 Channel at 0 receives 10 beats -> stays 0, no end_pulse; load len 0 -> no end_pulse, note_did_end high next cycle.
REQ-036 Reset asserted with ch0 at 2 and beat high -> next cycle all remaining 0, end_pulse 0, all_done 1.
